// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] BUBBLE_IS        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] npc;
        logic [31:0] pc;
    } ifid_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_buf_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_reg.sv
// Generic register with write-enable and synchronous active-high reset.
module if_fetch_reg #(
    parameter int unsigned     Width    = 32,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= ResetVal;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: FETCH/FULL/DROP FSM feeding the IF/ID register.
// Define IF_FETCH_PERF_EN to add the fetch_cnt/stall_cnt performance counters.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_dout,
    output logic [31:0] npc_dout,
    output logic [31:0] is_dout,
    output logic        valid_dout
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    ifid_t        out_q, out_d, bubble;
    fetch_buf_t   buf_q, buf_d;
    logic         out_we, buf_we;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    if_fetch_reg #(.Width(32), .ResetVal(RESET_PC)) u_pc_reg (
        .clk_i (clk),
        .rst_i (rstn),
        .en_i  (1'b1),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    if_fetch_reg #(.Width($bits(ifid_t))) u_out_reg (
        .clk_i (clk),
        .rst_i (rstn),
        .en_i  (out_we),
        .d_i   (out_d),
        .q_o   (out_q)
    );

    // Holds a stalled response in FULL, or the outstanding address in DROP.
    if_fetch_reg #(.Width($bits(fetch_buf_t))) u_buf_reg (
        .clk_i (clk),
        .rst_i (rstn),
        .en_i  (buf_we),
        .d_i   (buf_d),
        .q_o   (buf_q)
    );

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        out_we          = 1'b0;
        out_d           = out_q;
        buf_we          = 1'b0;
        buf_d           = '{instr: im_rdata, pc: pc_q};
        bubble          = out_q;
        bubble.valid    = 1'b0;
        bubble.instr    = BUBBLE_IS;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d   = word_align(redirect_pc);
                    out_we = 1'b1;
                    out_d  = bubble;
                    if (!im_ack) begin
                        buf_we  = 1'b1;
                        state_d = DROP;
                    end
                end else if (stall) begin
                    if (im_ack) begin
                        buf_we  = 1'b1;
                        state_d = FULL;
                    end
                end else if (im_ack) begin
                    out_we = 1'b1;
                    out_d  = '{valid: 1'b1, instr: im_rdata, npc: pc_q + 32'd4, pc: pc_q};
                    pc_d   = pc_q + 32'd4;
                end else begin
                    out_we = 1'b1;
                    out_d  = bubble;
                end
            end
            FULL: begin
                if (redirect) begin
                    pc_d    = word_align(redirect_pc);
                    out_we  = 1'b1;
                    out_d   = bubble;
                    buf_we  = 1'b1;
                    buf_d   = '0;
                    state_d = FETCH;
                end else if (!stall) begin
                    out_we  = 1'b1;
                    out_d   = '{valid: 1'b1, instr: buf_q.instr, npc: buf_q.pc + 32'd4,
                                pc: buf_q.pc};
                    pc_d    = buf_q.pc + 32'd4;
                    state_d = FETCH;
                end
            end
            DROP: begin
                // The response to the old address is never delivered.
                if (redirect) begin
                    pc_d   = word_align(redirect_pc);
                    out_we = 1'b1;
                    out_d  = bubble;
                end else if (!stall) begin
                    out_we = 1'b1;
                    out_d  = bubble;
                end
                if (im_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign im_req     = !rstn && (state_q != FULL);
    assign im_addr    = (state_q == DROP) ? buf_q.pc : pc_q;
    assign pc_dout    = out_q.pc;
    assign npc_dout   = out_q.npc;
    assign is_dout    = out_q.instr;
    assign valid_dout = out_q.valid;

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rstn) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_we && out_d.valid) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rstn, stall, redirect, im_ack, echo;
    logic [31:0] redirect_pc, rdata_drv, im_rdata, im_addr;
    logic [31:0] pc_dout, npc_dout, is_dout;
    logic        im_req, valid_dout;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Echo mode returns the fetch address as the instruction word.
    assign im_rdata = echo ? im_addr : rdata_drv;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .pc_dout     (pc_dout),
        .npc_dout    (npc_dout),
        .is_dout     (is_dout),
        .valid_dout  (valid_dout)
`ifdef IF_FETCH_PERF_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn        = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        im_ack      = 1'b0;
        echo        = 1'b0;
        rdata_drv   = 32'h0;

        tick();
        tick();
        check("rst_req",   {31'b0, im_req}, 32'h0);
        check("rst_valid", {31'b0, valid_dout}, 32'h0);
        check("rst_pc",    pc_dout, 32'h0);
        check("rst_is",    is_dout, 32'h0);
        rstn = 1'b0;
        #1;
        check("first_req",  {31'b0, im_req}, 32'h1);
        check("first_addr", im_addr, 32'h0);

        // Zero-wait memory, one instruction per cycle.
        im_ack = 1'b1;
        echo   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_pc",    pc_dout, 32'(4 * i));
            check("seq_npc",   npc_dout, 32'(4 * i + 4));
            check("seq_is",    is_dout, 32'(4 * i));
            check("seq_valid", {31'b0, valid_dout}, 32'h1);
        end

        // Stall on the cycle 0xAA returns at address 0xC.
        echo      = 1'b0;
        rdata_drv = 32'h0000_00AA;
        stall     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            im_ack = 1'b0;
            #1;
            check("stall_pc",  pc_dout, 32'h8);
            check("stall_is",  is_dout, 32'h8);
            check("stall_req", {31'b0, im_req}, 32'h0);
        end
        stall = 1'b0;
        tick();
        check("unstall_is",    is_dout, 32'hAA);
        check("unstall_pc",    pc_dout, 32'hC);
        check("unstall_npc",   npc_dout, 32'h10);
        check("unstall_valid", {31'b0, valid_dout}, 32'h1);
        check("unstall_addr",  im_addr, 32'h10);

        // Slow memory: no ack gives a bubble, then redirect while waiting.
        tick();
        check("bubble_valid", {31'b0, valid_dout}, 32'h0);
        check("bubble_is",    is_dout, 32'h0);
        check("bubble_pc",    pc_dout, 32'hC);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("drop_req",   {31'b0, im_req}, 32'h1);
        check("drop_addr",  im_addr, 32'h10);
        check("drop_valid", {31'b0, valid_dout}, 32'h0);
        im_ack    = 1'b1;
        rdata_drv = 32'h0000_DEAD;
        tick();
        check("dropped_valid", {31'b0, valid_dout}, 32'h0);
        check("redir_addr",    im_addr, 32'h100);
        rdata_drv = 32'h0000_1234;
        tick();
        check("redir_valid", {31'b0, valid_dout}, 32'h1);
        check("redir_pc",    pc_dout, 32'h100);
        check("redir_is",    is_dout, 32'h1234);

        // Redirect, stall and ack together: redirect wins.
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        stall       = 1'b1;
        rdata_drv   = 32'h0000_5555;
        tick();
        check("prio_valid", {31'b0, valid_dout}, 32'h0);
        check("prio_is",    is_dout, 32'h0);
        check("prio_addr",  im_addr, 32'h200);
        check("prio_req",   {31'b0, im_req}, 32'h1);

        // Unaligned target near the top of the address space wraps.
        redirect_pc = 32'hFFFF_FFFE;
        stall       = 1'b0;
        tick();
        redirect = 1'b0;
        check("wrap_addr0", im_addr, 32'hFFFF_FFFC);
        echo = 1'b1;
        tick();
        check("wrap_addr1", im_addr, 32'h0);
        check("wrap_pc",    pc_dout, 32'hFFFF_FFFC);
        check("wrap_npc",   npc_dout, 32'h0);

        // Reset while holding a buffered response.
        stall = 1'b1;
        tick();
        rstn = 1'b1;
        tick();
        check("rstfull_req",   {31'b0, im_req}, 32'h0);
        check("rstfull_valid", {31'b0, valid_dout}, 32'h0);
        check("rstfull_pc",    pc_dout, 32'h0);
        rstn  = 1'b0;
        stall = 1'b0;
        #1;
        check("rstfull_addr", im_addr, 32'h0);
        check("rstfull_req1", {31'b0, im_req}, 32'h1);

`ifdef IF_FETCH_PERF_EN
        check("cnt_fetch0", fetch_cnt, 32'h0);
        check("cnt_stall0", stall_cnt, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        im_ack = 1'b0;
        stall  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        stall = 1'b0;
        check("cnt_fetch", fetch_cnt, 32'd10);
        check("cnt_stall", stall_cnt, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
